// File: rtl/aluop_sel_pipe_if.sv
// ID/EX control-select bus: candidates and hazard controls in, registered control word out.
// The master drives candidates/controls and consumes the registered outputs; the slave is the pipe stage.
interface aluop_sel_pipe_if #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned STALL_CNT_W = 4
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    valid_in;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        op;
    logic                    valid_out;
    logic [STALL_CNT_W-1:0]  stall_cnt;
    logic                    sel_err;

    modport master (
        output in_bus, sel, valid_in, stall, flush,
        input  op, valid_out, stall_cnt, sel_err
    );

    modport slave (
        input  in_bus, sel, valid_in, stall, flush,
        output op, valid_out, stall_cnt, sel_err
    );
endinterface

// File: rtl/aluop_sel_pipe.sv
// N-way ALU-op selector registered into EX, with hazard-unit stall/flush and a saturating stall counter.
// Optional sticky out-of-range select flag enabled by defining ALUOP_SEL_CHECK_EN.
module aluop_sel_pipe #(
    parameter int unsigned      WIDTH       = 2,
    parameter int unsigned      NUM_IN      = 4,
    parameter int unsigned      SEL_W       = 2,
    parameter logic [WIDTH-1:0] NOP_VAL     = '0,
    parameter int unsigned      STALL_CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    aluop_sel_pipe_if.slave   bus
);

    // Elaboration-time parameter sanity.
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("aluop_sel_pipe: NUM_IN must be in 2..16");
    end
    if ((32'd1 << SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("aluop_sel_pipe: SEL_W too narrow for NUM_IN");
    end

    logic [WIDTH-1:0]       sel_word_c;
    logic [WIDTH-1:0]       op_q;
    logic                   valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Compare-based mux: selects beyond NUM_IN never index past in_bus and fall back to NOP_VAL.
    always_comb begin
        sel_word_c = NOP_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_word_c = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pipeline register: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= NOP_VAL;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else if (bus.flush) begin
            op_q        <= NOP_VAL;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else if (bus.stall) begin
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            op_q        <= sel_word_c;
            valid_q     <= bus.valid_in;
            stall_cnt_q <= '0;
        end
    end

    assign bus.op        = op_q;
    assign bus.valid_out = valid_q;
    assign bus.stall_cnt = stall_cnt_q;

`ifdef ALUOP_SEL_CHECK_EN
    logic sel_oor_c;
    logic sel_err_q;

    assign sel_oor_c = (32'(bus.sel) >= NUM_IN);

    // Sticky until reset; flush deliberately leaves it alone so the event is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (!bus.flush && !bus.stall && sel_oor_c) begin
            sel_err_q <= 1'b1;
            if (!sel_err_q) begin
                $display("aluop_sel_pipe: out-of-range select %0d (NUM_IN=%0d)", bus.sel, NUM_IN);
            end
        end
    end

    assign bus.sel_err = sel_err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_aluop_sel_pipe.sv
// Directed bench for aluop_sel_pipe: a 4-input instance and a 3-input instance for out-of-range selects.
module tb_aluop_sel_pipe;

`ifdef ALUOP_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    logic rst_b;
    int   checks;
    int   failures;

    aluop_sel_pipe_if #(.WIDTH(2), .NUM_IN(4), .SEL_W(2), .STALL_CNT_W(4)) bus_a ();
    aluop_sel_pipe_if #(.WIDTH(2), .NUM_IN(3), .SEL_W(2), .STALL_CNT_W(4)) bus_b ();

    aluop_sel_pipe #(.WIDTH(2), .NUM_IN(4), .SEL_W(2), .NOP_VAL(2'b00), .STALL_CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    aluop_sel_pipe #(.WIDTH(2), .NUM_IN(3), .SEL_W(2), .NOP_VAL(2'b00), .STALL_CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.in_bus = 8'hE4; bus_a.sel = 2'd3; bus_a.valid_in = 1'b1;
        bus_a.stall = 1'b0;   bus_a.flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus_a.op !== 2'd0 || bus_a.valid_out !== 1'b0 || bus_a.stall_cnt !== 4'd0 || bus_a.sel_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d op=%0d vld=%0d cnt=%0d err=%0d want 0/0/0/0",
                         i, bus_a.op, bus_a.valid_out, bus_a.stall_cnt, bus_a.sel_err);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus_a.op !== 2'd3 || bus_a.valid_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_release op=%0d vld=%0d want 3/1", bus_a.op, bus_a.valid_out);
        end
    endtask

    task automatic test_select_sweep();
        logic [1:0] exp_op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int s = 0; s < 4; s++) begin
            bus_a.sel = 2'(s);
            step();
            checks++;
            if (bus_a.op !== exp_op[s] || bus_a.valid_out !== 1'b1) begin
                failures++;
                $display("FAIL sweep sel=%0d op=%0d vld=%0d want %0d/1", s, bus_a.op, bus_a.valid_out, exp_op[s]);
            end
        end
    endtask

    task automatic test_stall_saturate();
        logic [3:0] exp_cnt;
        bus_a.sel = 2'd2;
        step();
        checks++;
        if (bus_a.op !== 2'd2) begin
            failures++;
            $display("FAIL stall_pre op=%0d want 2", bus_a.op);
        end
        bus_a.stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            bus_a.sel = 2'(i);
            step();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (bus_a.op !== 2'd2 || bus_a.valid_out !== 1'b1 || bus_a.stall_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL stall_hold i=%0d op=%0d vld=%0d cnt=%0d want 2/1/%0d",
                         i, bus_a.op, bus_a.valid_out, bus_a.stall_cnt, exp_cnt);
            end
        end
        bus_a.stall = 1'b0;
        bus_a.sel = 2'd1;
        step();
        checks++;
        if (bus_a.op !== 2'd1 || bus_a.stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL stall_release op=%0d cnt=%0d want 1/0", bus_a.op, bus_a.stall_cnt);
        end
    endtask

    task automatic test_flush_vs_stall();
        bus_a.sel = 2'd3;
        step();
        bus_a.stall = 1'b1;
        step();
        checks++;
        if (bus_a.op !== 2'd3 || bus_a.valid_out !== 1'b1 || bus_a.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL flush_pre op=%0d vld=%0d cnt=%0d want 3/1/1", bus_a.op, bus_a.valid_out, bus_a.stall_cnt);
        end
        bus_a.flush = 1'b1;
        step();
        checks++;
        if (bus_a.op !== 2'd0 || bus_a.valid_out !== 1'b0 || bus_a.stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL flush_over_stall op=%0d vld=%0d cnt=%0d want 0/0/0", bus_a.op, bus_a.valid_out, bus_a.stall_cnt);
        end
        bus_a.flush = 1'b0;
        step();
        checks++;
        if (bus_a.op !== 2'd0 || bus_a.valid_out !== 1'b0 || bus_a.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL post_flush_stall op=%0d vld=%0d cnt=%0d want 0/0/1", bus_a.op, bus_a.valid_out, bus_a.stall_cnt);
        end
        bus_a.stall = 1'b0;
    endtask

    task automatic test_invalid_load();
        bus_a.valid_in = 1'b0;
        bus_a.sel = 2'd2;
        step();
        checks++;
        if (bus_a.op !== 2'd2 || bus_a.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL invalid_load op=%0d vld=%0d want 2/0", bus_a.op, bus_a.valid_out);
        end
        bus_a.valid_in = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        bus_a.sel = 2'd1;
        step();
        bus_a.stall = 1'b1;
        repeat (5) step();
        checks++;
        if (bus_a.op !== 2'd1 || bus_a.stall_cnt !== 4'd5) begin
            failures++;
            $display("FAIL mid_pre op=%0d cnt=%0d want 1/5", bus_a.op, bus_a.stall_cnt);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus_a.op !== 2'd0 || bus_a.valid_out !== 1'b0 || bus_a.stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset op=%0d vld=%0d cnt=%0d want 0/0/0", bus_a.op, bus_a.valid_out, bus_a.stall_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus_a.op !== 2'd0 || bus_a.valid_out !== 1'b0 || bus_a.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL mid_restall op=%0d vld=%0d cnt=%0d want 0/0/1", bus_a.op, bus_a.valid_out, bus_a.stall_cnt);
        end
        bus_a.stall = 1'b0;
    endtask

    task automatic test_out_of_range();
        bus_b.in_bus = 6'h24; bus_b.sel = 2'd2; bus_b.valid_in = 1'b1;
        bus_b.stall = 1'b0;   bus_b.flush = 1'b0;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        step();
        checks++;
        if (bus_b.op !== 2'd2 || bus_b.sel_err !== 1'b0) begin
            failures++;
            $display("FAIL oor_legal op=%0d err=%0d want 2/0", bus_b.op, bus_b.sel_err);
        end
        bus_b.sel = 2'd3;
        step();
        checks++;
        if (bus_b.op !== 2'd0 || bus_b.valid_out !== 1'b1 || bus_b.sel_err !== CHK) begin
            failures++;
            $display("FAIL oor_select op=%0d vld=%0d err=%0d want 0/1/%0d", bus_b.op, bus_b.valid_out, bus_b.sel_err, CHK);
        end
        bus_b.flush = 1'b1;
        step();
        bus_b.flush = 1'b0;
        checks++;
        if (bus_b.op !== 2'd0 || bus_b.valid_out !== 1'b0 || bus_b.sel_err !== CHK) begin
            failures++;
            $display("FAIL oor_flush op=%0d vld=%0d err=%0d want 0/0/%0d", bus_b.op, bus_b.valid_out, bus_b.sel_err, CHK);
        end
        bus_b.sel = 2'd1;
        step();
        checks++;
        if (bus_b.op !== 2'd1 || bus_b.sel_err !== CHK) begin
            failures++;
            $display("FAIL oor_sticky op=%0d err=%0d want 1/%0d", bus_b.op, bus_b.sel_err, CHK);
        end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        checks++;
        if (bus_b.op !== 2'd0 || bus_b.sel_err !== 1'b0) begin
            failures++;
            $display("FAIL oor_reset op=%0d err=%0d want 0/0", bus_b.op, bus_b.sel_err);
        end
        checks++;
        if (bus_a.sel_err !== 1'b0) begin
            failures++;
            $display("FAIL inrange_err err=%0d want 0", bus_a.sel_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_b    = 1'b1;
        bus_b.in_bus = 6'h24; bus_b.sel = 2'd0; bus_b.valid_in = 1'b0;
        bus_b.stall = 1'b0;   bus_b.flush = 1'b0;
        test_reset();
        test_select_sweep();
        test_stall_saturate();
        test_flush_vs_stall();
        test_invalid_load();
        test_reset_mid_stall();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
